score_display: RTL and testbench

Converts the game's 20-bit binary score into six decimal digits and drives six seven-segment displays. It sits directly downstream of the Flappy Bird top level and consumes its `score` bus. It runs on `sys_clk` (50 MHz). It uses a sequential shift-and-add-3 (double-dabble) converter, so no wide combinational divider is needed.

---
 rtl/score_display_pkg.sv | 41 ++++
 rtl/score_display_seg7_encode.sv | 39 +++
 rtl/score_display.sv | 137 +++++++++++++
 tb/tb_score_display.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
//-----------------------------------------------------------------------------
// score_display_pkg
//   Shared types and constants for the score display path: FSM state
//   encoding, seven-segment codes (active-low, {g,f,e,d,c,b,a}), the
//   saturation limit and the BCD add-3 helper used by the converter.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SCORE_MAX  = 999999;
  localparam int BCD_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Double-dabble correction: a nibble of 5 or more would exceed 9 after
  // the next doubling, so pre-add 3 to carry it into the next digit.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

`default_nettype wire

// File: rtl/score_display_seg7_encode.sv
//-----------------------------------------------------------------------------
// seg7_encode
//   Combinational BCD digit to active-low seven-segment code. A set blank
//   flag, or a non-decimal digit, turns all segments off.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module seg7_encode
  import score_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Digit lookup with blank override
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/score_display.sv
//-----------------------------------------------------------------------------
// score_display
//   Converts the binary game score into six decimal digits with a serial
//   shift-and-add-3 converter and drives six active-low seven-segment
//   displays. Scores above 999999 saturate and raise overflow. Display
//   registers only update at the end of a conversion.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module score_display
  import score_display_pkg::*;
#(
  parameter int SCORE_W    = 20,
  parameter bit LEAD_BLANK = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [SCORE_W-1:0] score,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1,
  output logic [6:0]         hex2,
  output logic [6:0]         hex3,
  output logic [6:0]         hex4,
  output logic [6:0]         hex5,
  output logic               busy,
  output logic               overflow
);

  localparam int CNT_W = ($clog2(SCORE_W) > 0) ? $clog2(SCORE_W) : 1;
  localparam logic [CNT_W-1:0]   c_cnt_last = CNT_W'(SCORE_W - 1);
  localparam logic [SCORE_W-1:0] c_work_max = SCORE_W'(SCORE_MAX);
  localparam logic [6:0]         c_hex_rst  = LEAD_BLANK ? SEG_BLANK : SEG_0;

  state_t                    r_state;
  logic [SCORE_W-1:0]        r_score_s;
  logic [SCORE_W-1:0]        r_last_score;
  logic [SCORE_W-1:0]        r_work;
  logic [4*BCD_DIGITS-1:0]   r_bcd;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_ovf_n;

  logic                      w_over;
  logic [4*BCD_DIGITS-1:0]   w_bcd_adj;
  logic [BCD_DIGITS-1:0]     w_blank;
  logic [6:0]                w_seg [BCD_DIGITS];

  // Score comes from a clock derived from sys_clk, one register suffices
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_score_s <= '0;
    else            r_score_s <= score;
  end

  assign w_over = (64'(r_score_s) > 64'(SCORE_MAX));

  // Add-3 correction applied to every BCD nibble before each shift
  always_comb begin
    w_bcd_adj = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      w_bcd_adj[4*i +: 4] = add3_if_ge5(r_bcd[4*i +: 4]);
    end
  end

  // Leading-zero blanking: a digit blanks when it and every higher digit are
  // zero; the units digit is always shown
  always_comb begin
    logic v_hi_zero;
    w_blank   = '0;
    v_hi_zero = 1'b1;
    for (int k = BCD_DIGITS - 1; k >= 1; k--) begin
      v_hi_zero  = v_hi_zero & (r_bcd[4*k +: 4] == 4'd0);
      w_blank[k] = LEAD_BLANK & v_hi_zero;
    end
  end

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_seg
    seg7_encode u_seg7_encode (
      .digit (r_bcd[4*i +: 4]),
      .blank (w_blank[i]),
      .seg   (w_seg[i])
    );
  end

  // Conversion FSM: accept a changed score, shift SCORE_W times, then latch
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= IDLE;
      r_last_score <= '0;
      r_work       <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_ovf_n      <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      hex0         <= SEG_0;
      hex1         <= c_hex_rst;
      hex2         <= c_hex_rst;
      hex3         <= c_hex_rst;
      hex4         <= c_hex_rst;
      hex5         <= c_hex_rst;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_score_s != r_last_score) begin
            r_last_score <= r_score_s;
            r_work       <= w_over ? c_work_max : r_score_s;
            r_ovf_n      <= w_over;
            r_bcd        <= '0;
            r_cnt        <= '0;
            busy         <= 1'b1;
            r_state      <= SHIFT;
          end
        end
        SHIFT: begin
          {r_bcd, r_work} <= {w_bcd_adj, r_work} << 1;
          r_cnt           <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_last) r_state <= DONE;
        end
        DONE: begin
          hex0     <= w_seg[0];
          hex1     <= w_seg[1];
          hex2     <= w_seg[2];
          hex3     <= w_seg[3];
          hex4     <= w_seg[4];
          hex5     <= w_seg[5];
          overflow <= r_ovf_n;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_score_display.sv
//-----------------------------------------------------------------------------
// tb_score_display
//   Directed self-checking bench for score_display. Expected displays are
//   computed from the decimal value of each driven score and queued; they
//   are popped and compared when the conversion completes.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_score_display;

  typedef struct packed {
    logic            ovf;
    logic [5:0][6:0] h;
  } exp_t;

  logic            sys_clk;
  logic            sys_rst_n;
  logic [19:0]     score;
  logic [6:0]      hex0, hex1, hex2, hex3, hex4, hex5;
  logic            busy;
  logic            overflow;
  logic [5:0][6:0] hexv;

  int   total;
  int   bad;
  exp_t sb[$];
  exp_t shown;

  score_display #(
    .SCORE_W    (20),
    .LEAD_BLANK (1'b1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .score     (score),
    .hex0      (hex0),
    .hex1      (hex1),
    .hex2      (hex2),
    .hex3      (hex3),
    .hex4      (hex4),
    .hex5      (hex5),
    .busy      (busy),
    .overflow  (overflow)
  );

  assign hexv = {hex5, hex4, hex3, hex2, hex1, hex0};

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'h40;
      1:       return 7'h79;
      2:       return 7'h24;
      3:       return 7'h30;
      4:       return 7'h19;
      5:       return 7'h12;
      6:       return 7'h02;
      7:       return 7'h78;
      8:       return 7'h00;
      9:       return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference display for a score: saturate, split into decimal digits,
  // blank digit k>=1 when the value is below 10^k
  function automatic exp_t model(input int v);
    exp_t e;
    int   s;
    int   p;
    e.ovf = (v > 999999);
    s     = e.ovf ? 999999 : v;
    p     = 1;
    for (int k = 0; k < 6; k++) begin
      e.h[k] = (k > 0 && s < p) ? 7'h7F : seg_of((s / p) % 10);
      p      = p * 10;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      for (int k = 0; k < 6; k++) check($sformatf("%s_hex%0d", tag, k), 32'(hexv[k]), 32'(e.h[k]));
      check({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
      shown = e;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hex0"}, 32'(hex0), 32'h40);
    for (int k = 1; k < 6; k++) check($sformatf("%s_hex%0d", tag, k), 32'(hexv[k]), 32'h7F);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  // Drive a new score just after an edge and follow the fixed 23-edge
  // conversion window, checking busy profile and display stability
  task automatic convert(input int v, input string tag);
    int bc;
    int first;
    bc    = 0;
    first = 0;
    score = 20'(v);
    sb.push_back(model(v));
    for (int e = 1; e <= 23; e++) begin
      @(posedge sys_clk);
      #1;
      if (busy) begin
        bc++;
        if (first == 0) first = e;
      end
      if (e == 22) check({tag, "_stable"}, 32'(hexv), 32'(shown.h));
    end
    check({tag, "_busy_cycles"}, 32'(bc), 32'd21);
    check({tag, "_busy_first"}, 32'(first), 32'd2);
    check_pop(tag);
  endtask

  initial begin
    int bc;
    int saw;
    total     = 0;
    bad       = 0;
    sys_rst_n = 1'b0;
    score     = '0;
    shown     = model(0);

    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_vals("rst");
    sys_rst_n = 1'b1;
    saw = 0;
    for (int e = 0; e < 100; e++) begin
      @(posedge sys_clk);
      #1;
      if (busy) saw = 1;
    end
    check("idle_no_busy", 32'(saw), 32'd0);
    check_reset_vals("idle");

    convert(123, "s123");
    convert(100000, "s100000");
    convert(1048575, "ssat");
    convert(7, "s7");

    // Score change in mid-conversion is picked up by the next conversion
    bc    = 0;
    score = 20'd5;
    sb.push_back(model(5));
    for (int e = 1; e <= 45; e++) begin
      @(posedge sys_clk);
      #1;
      if (busy) bc++;
      if (e == 10) begin
        score = 20'd42;
        sb.push_back(model(42));
      end
      if (e == 23) begin
        check("s5_busy_low", 32'(busy), 32'd0);
        check_pop("s5");
      end
      if (e == 24) check("s42_busy_start", 32'(busy), 32'd1);
    end
    check("s42_busy_low", 32'(busy), 32'd0);
    check("s5s42_busy_cycles", 32'(bc), 32'd42);
    check_pop("s42");

    // Asynchronous reset in the middle of the shift phase
    score = 20'd999;
    repeat (8) @(posedge sys_clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    shown     = model(0);
    convert(999, "s999");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
